// File: rtl/kfmmc_pkg.sv
// rtl/kfmmc_pkg.sv - shared types and CRC7 step for the KFMMC line engines
package kfmmc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        SHIFT
    } phy_state_t;

    localparam logic [6:0] CRC7_POLY = 7'h09;

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first data.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic data_bit);
        logic fb;
        fb = data_bit ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/kfmmc_command_phy_if.sv
// rtl/kfmmc_command_phy_if.sv - sequencer-side bus and CMD-line pins of the command PHY
interface kfmmc_command_phy_if;
    logic       start_communication;
    logic       command_io;
    logic       check_command_start_bit;
    logic       clear_command_crc;
    logic       clear_command_interrupt;
    logic       mask_command_interrupt;
    logic       set_send_command;
    logic [7:0] send_command;
    logic [7:0] received_response;
    logic [6:0] send_command_crc;
    logic [6:0] received_response_crc;
    logic       in_connecting;
    logic       sent_command_interrupt;
    logic       received_response_interrupt;
    logic       response_timeout;
    logic       mmc_clk;
    logic       mmc_cmd_out;
    logic       mmc_cmd_oe;
    logic       mmc_cmd_in;

    modport master (
        output start_communication, command_io, check_command_start_bit, clear_command_crc,
               clear_command_interrupt, mask_command_interrupt, set_send_command, send_command,
               mmc_cmd_in,
        input  received_response, send_command_crc, received_response_crc, in_connecting,
               sent_command_interrupt, received_response_interrupt, response_timeout,
               mmc_clk, mmc_cmd_out, mmc_cmd_oe
    );

    modport slave (
        input  start_communication, command_io, check_command_start_bit, clear_command_crc,
               clear_command_interrupt, mask_command_interrupt, set_send_command, send_command,
               mmc_cmd_in,
        output received_response, send_command_crc, received_response_crc, in_connecting,
               sent_command_interrupt, received_response_interrupt, response_timeout,
               mmc_clk, mmc_cmd_out, mmc_cmd_oe
    );
endinterface

// File: rtl/kfmmc_crc7.sv
// rtl/kfmmc_crc7.sv - serial CRC7 register with clear and bit-enable
module kfmmc_crc7
    import kfmmc_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [6:0] o_crc
);
    logic [6:0] r_crc;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_crc <= 7'h00;
        end else if (i_clear) begin
            r_crc <= 7'h00;
        end else if (i_en) begin
            r_crc <= crc7_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;
endmodule

// File: rtl/kfmmc_command_phy.sv
// rtl/kfmmc_command_phy.sv - bit-level CMD-line engine: one byte out or in per request
module kfmmc_command_phy
    import kfmmc_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int START_TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    kfmmc_command_phy_if.slave   bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);

    phy_state_t       r_state;
    logic             r_dir;
    logic             r_half;
    logic             r_mmc_clk;
    logic             r_oe;
    logic             r_tx_flag;
    logic             r_rx_flag;
    logic             r_timeout;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_bit_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [7:0]       r_tx_shift;
    logic [7:0]       r_rx_shift;
    logic [7:0]       r_rx_byte;

    logic w_start;
    logic w_tick;
    logic w_rise;
    logic w_fall;
    logic w_rx_take;
    logic w_crc_clear;

    assign w_start     = bus.start_communication && (r_state == IDLE);
    assign w_tick      = (r_state != IDLE) && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_rise      = w_tick && !r_half;
    assign w_fall      = w_tick && r_half;
    // While hunting for the start bit, idle 1s are neither shifted nor CRC'd.
    assign w_rx_take   = w_rise && r_dir && ((r_state == SHIFT) || !bus.mmc_cmd_in);
    assign w_crc_clear = w_start && bus.clear_command_crc;

    kfmmc_crc7 u_tx_crc (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_crc_clear),
        .i_en    (w_rise && !r_dir),
        .i_bit   (r_tx_shift[7]),
        .o_crc   (bus.send_command_crc)
    );

    kfmmc_crc7 u_rx_crc (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_crc_clear),
        .i_en    (w_rx_take),
        .i_bit   (bus.mmc_cmd_in),
        .o_crc   (bus.received_response_crc)
    );

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dir      <= 1'b0;
            r_half     <= 1'b0;
            r_mmc_clk  <= 1'b0;
            r_oe       <= 1'b0;
            r_tx_flag  <= 1'b0;
            r_rx_flag  <= 1'b0;
            r_timeout  <= 1'b0;
            r_div      <= '0;
            r_bit_cnt  <= 4'd0;
            r_to_cnt   <= '0;
            r_tx_shift <= 8'hFF;
            r_rx_shift <= 8'hFF;
            r_rx_byte  <= 8'hFF;
        end else begin
            if (bus.clear_command_interrupt) begin
                r_tx_flag <= 1'b0;
                r_rx_flag <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_dir     <= bus.command_io;
                        r_oe      <= ~bus.command_io;
                        r_div     <= '0;
                        r_half    <= 1'b0;
                        r_bit_cnt <= 4'd8;
                        r_to_cnt  <= '0;
                        r_timeout <= 1'b0;
                        if (bus.set_send_command)
                            r_tx_shift <= bus.send_command;
                        r_state <= (bus.command_io && bus.check_command_start_bit) ? WAIT_START : SHIFT;
                    end
                end
                default: begin
                    r_div <= w_tick ? '0 : r_div + 1'b1;
                    if (w_rise) begin
                        r_mmc_clk <= 1'b1;
                        r_half    <= 1'b1;
                        if (w_rx_take)
                            r_rx_shift <= {r_rx_shift[6:0], bus.mmc_cmd_in};
                        if (r_state == WAIT_START) begin
                            if (bus.mmc_cmd_in)
                                r_to_cnt <= r_to_cnt + 1'b1;
                            else
                                r_state <= SHIFT;
                        end
                    end
                    if (w_fall) begin
                        r_mmc_clk <= 1'b0;
                        r_half    <= 1'b0;
                        if (!r_dir)
                            r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                        if (r_state == SHIFT) begin
                            r_bit_cnt <= r_bit_cnt - 4'd1;
                            if (r_bit_cnt == 4'd1) begin
                                r_state <= IDLE;
                                if (r_dir) begin
                                    r_rx_byte <= r_rx_shift;
                                    r_rx_flag <= 1'b1;
                                end else begin
                                    r_tx_flag <= 1'b1;
                                end
                            end
                        end else if (r_to_cnt == TO_W'(START_TIMEOUT)) begin
                            r_state   <= IDLE;
                            r_rx_byte <= 8'hFF;
                            r_timeout <= 1'b1;
                            r_rx_flag <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_connecting               = (r_state != IDLE) || bus.start_communication;
    assign bus.received_response           = r_rx_byte;
    assign bus.sent_command_interrupt      = r_tx_flag && !bus.mask_command_interrupt;
    assign bus.received_response_interrupt = r_rx_flag && !bus.mask_command_interrupt;
    assign bus.response_timeout            = r_timeout;
    assign bus.mmc_clk                     = r_mmc_clk;
    assign bus.mmc_cmd_oe                  = r_oe;
    assign bus.mmc_cmd_out                 = ((r_state != IDLE) && !r_dir) ? r_tx_shift[7] : 1'b1;
endmodule

// File: tb/tb_kfmmc_command_phy.sv
// tb/tb_kfmmc_command_phy.sv - randomized self-checking bench for kfmmc_command_phy
module tb_kfmmc_command_phy;
    localparam int START_TIMEOUT = 64;
    localparam int BOUND         = 3000;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    bit   tx_bits[$];
    bit   rx_bits[$];
    bit   card_q[$];

    kfmmc_command_phy_if bus();

    kfmmc_command_phy #(.CLK_DIV(4), .START_TIMEOUT(START_TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] crc_div(input bit q[$]);
        bit         a[$];
        logic [7:0] g;
        logic [6:0] r;
        g = 8'h89;
        a = q;
        repeat (7) a.push_back(1'b0);
        for (int i = 0; i < q.size(); i++)
            if (a[i])
                for (int k = 0; k < 8; k++) a[i+k] = a[i+k] ^ g[7-k];
        for (int k = 0; k < 7; k++) r[6-k] = a[q.size()+k];
        return r;
    endfunction

    task automatic clr_int();
        @(posedge clock); #1;
        bus.clear_command_interrupt = 1'b1;
        @(posedge clock); #1;
        bus.clear_command_interrupt = 1'b0;
        chk("tx_int_cleared", bus.sent_command_interrupt, 0);
        chk("rx_int_cleared", bus.received_response_interrupt, 0);
    endtask

    // One byte transfer; the card replays card_q (1s once exhausted), changing on mmc_clk falls.
    task automatic xfer(input bit dir, input bit cs, input bit clr, input logic [7:0] b);
        bit         stream[$];
        int         idx, pos, rises, cyc, exp_rises;
        logic [7:0] cap, exp_rx;
        bit         to;
        logic       prev;
        stream = card_q;
        to     = 1'b0;
        exp_rx = 8'hFF;
        if (clr) begin
            tx_bits.delete();
            rx_bits.delete();
        end
        if (!dir) begin
            for (int i = 7; i >= 0; i--) tx_bits.push_back(b[i]);
            exp_rises = 8;
        end else begin
            idx = 0;
            if (cs)
                while (idx < START_TIMEOUT && (idx >= stream.size() || stream[idx])) idx++;
            to = cs && (idx >= START_TIMEOUT);
            if (to) begin
                exp_rises = START_TIMEOUT;
            end else begin
                exp_rises = idx + 8;
                for (int k = 0; k < 8; k++) begin
                    exp_rx[7-k] = (idx + k < stream.size()) ? stream[idx+k] : 1'b1;
                    rx_bits.push_back(exp_rx[7-k]);
                end
            end
        end
        @(posedge clock); #1;
        bus.mmc_cmd_in              = (stream.size() > 0) ? stream[0] : 1'b1;
        pos                         = 1;
        bus.command_io              = dir;
        bus.check_command_start_bit = cs;
        bus.clear_command_crc       = clr;
        bus.set_send_command        = !dir;
        bus.send_command            = b;
        bus.start_communication     = 1'b1;
        #1 chk("in_connecting_at_start", bus.in_connecting, 1);
        @(posedge clock); #1;
        bus.start_communication = 1'b0;
        bus.clear_command_crc   = 1'b0;
        bus.set_send_command    = 1'b0;
        rises = 0;
        cyc   = 0;
        cap   = 8'h00;
        prev  = bus.mmc_clk;
        while (bus.in_connecting && cyc < BOUND) begin
            @(posedge clock);
            cyc++;
            if (bus.mmc_clk && !prev) begin
                rises++;
                cap = {cap[6:0], bus.mmc_cmd_out};
            end
            if (!bus.mmc_clk && prev) begin
                bus.mmc_cmd_in = (pos < stream.size()) ? stream[pos] : 1'b1;
                pos++;
            end
            prev = bus.mmc_clk;
        end
        chk("xfer_bound", cyc < BOUND, 1);
        chk("mmc_clk_rises", rises, exp_rises);
        chk("idle_mmc_clk", bus.mmc_clk, 0);
        chk("idle_cmd_out", bus.mmc_cmd_out, 1);
        if (!dir) begin
            chk("line_bits", cap, b);
            chk("tx_crc", bus.send_command_crc, crc_div(tx_bits));
            chk("tx_int", bus.sent_command_interrupt, !bus.mask_command_interrupt);
            chk("oe_tx", bus.mmc_cmd_oe, 1);
        end else begin
            chk("rx_byte", bus.received_response, exp_rx);
            chk("rx_timeout", bus.response_timeout, to);
            chk("rx_crc", bus.received_response_crc, crc_div(rx_bits));
            chk("rx_int", bus.received_response_interrupt, !bus.mask_command_interrupt);
            chk("oe_rx", bus.mmc_cmd_oe, 0);
        end
    endtask

    initial begin
        logic [7:0] b;
        int         n, cyc, rises;
        logic       prev;
        logic [7:0] cmd0 [5];
        logic [7:0] cmd8 [5];
        total = 0;
        bad   = 0;
        cmd0  = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        cmd8  = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};
        reset = 1'b1;
        bus.start_communication     = 1'b0;
        bus.command_io              = 1'b0;
        bus.check_command_start_bit = 1'b0;
        bus.clear_command_crc       = 1'b0;
        bus.clear_command_interrupt = 1'b0;
        bus.mask_command_interrupt  = 1'b0;
        bus.set_send_command        = 1'b0;
        bus.send_command            = 8'h00;
        bus.mmc_cmd_in              = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_mmc_clk", bus.mmc_clk, 0);
        chk("rst_cmd_out", bus.mmc_cmd_out, 1);
        chk("rst_oe", bus.mmc_cmd_oe, 0);
        chk("rst_rx_byte", bus.received_response, 8'hFF);
        chk("rst_tx_crc", bus.send_command_crc, 0);
        chk("rst_rx_crc", bus.received_response_crc, 0);
        chk("rst_ints", {bus.sent_command_interrupt, bus.received_response_interrupt}, 0);
        chk("rst_timeout", bus.response_timeout, 0);
        chk("rst_in_connecting", bus.in_connecting, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            xfer(1'b0, 1'b0, i == 0, cmd0[i]);
            clr_int();
        end
        chk("cmd0_crc", bus.send_command_crc, 7'h4A);
        for (int i = 0; i < 5; i++) begin
            xfer(1'b0, 1'b0, i == 0, cmd8[i]);
            clr_int();
        end
        chk("cmd8_crc", bus.send_command_crc, 7'h43);

        card_q = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
        xfer(1'b1, 1'b1, 1'b1, 8'h00);
        chk("resp_01", bus.received_response, 8'h01);
        clr_int();

        card_q.delete();
        xfer(1'b1, 1'b1, 1'b0, 8'h00);
        chk("timeout_flag", bus.response_timeout, 1);
        clr_int();

        bus.mask_command_interrupt = 1'b1;
        xfer(1'b0, 1'b0, 1'b0, 8'h5A);
        chk("timeout_cleared_by_start", bus.response_timeout, 0);
        bus.mask_command_interrupt = 1'b0;
        #1 chk("unmasked_tx_int", bus.sent_command_interrupt, 1);
        clr_int();

        for (int it = 0; it < 16; it++) begin
            b = 8'($urandom);
            card_q.delete();
            if ($urandom_range(0, 1) == 0) begin
                xfer(1'b0, 1'b0, 1'($urandom_range(0, 1)), b);
            end else begin
                n = $urandom_range(0, 10);
                repeat (n) card_q.push_back(1'b1);
                for (int k = 7; k >= 0; k--) card_q.push_back(b[k]);
                xfer(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h00);
            end
            clr_int();
        end

        @(posedge clock); #1;
        bus.command_io          = 1'b0;
        bus.set_send_command    = 1'b1;
        bus.send_command        = 8'($urandom);
        bus.start_communication = 1'b1;
        @(posedge clock); #1;
        bus.start_communication = 1'b0;
        bus.set_send_command    = 1'b0;
        cyc   = 0;
        rises = 0;
        prev  = bus.mmc_clk;
        while (rises < 4 && cyc < BOUND) begin
            @(posedge clock);
            cyc++;
            if (bus.mmc_clk && !prev) rises++;
            prev = bus.mmc_clk;
        end
        chk("reset_wait_bound", cyc < BOUND, 1);
        #1 reset = 1'b1;
        #1;
        chk("midreset_oe", bus.mmc_cmd_oe, 0);
        chk("midreset_mmc_clk", bus.mmc_clk, 0);
        chk("midreset_in_connecting", bus.in_connecting, 0);
        chk("midreset_tx_crc", bus.send_command_crc, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        tx_bits.delete();
        rx_bits.delete();
        chk("midreset_no_tx_int", bus.sent_command_interrupt, 0);
        xfer(1'b0, 1'b0, 1'b0, 8'hA5);
        clr_int();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
